// File: rtl/audio_mixer.sv
// N-source stereo mixer: per-source gain, master gain, saturation and
// left-justification to 24 bits, time-multiplexed over one multiplier pair.
//   state | meaning
//   IDLE  | waiting for next_sample; inputs snapshotted on the strobe
//   ACCUM | one source per cycle: acc += sample * gain
//   SCALE | acc * master_gain >>> 8, saturate, load outputs
module audio_mixer #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next_sample,
  input  logic [N_SRC*WIDTH-1:0] src_left,
  input  logic [N_SRC*WIDTH-1:0] src_right,
  input  logic [N_SRC*5-1:0]     src_gain,
  input  logic [4:0]             master_gain,
  input  logic                   flags_clear,
  output logic [23:0]            left_data,
  output logic [23:0]            right_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   clip,
  output logic                   overrun
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int ACC_W = WIDTH + 6 + $clog2(N_SRC);
  localparam int SCL_W = ACC_W + 6;
  localparam logic signed [SCL_W-1:0] SAT_MAX =
    {{(SCL_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SCL_W-1:0] SAT_MIN =
    {{(SCL_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] snap_l [N_SRC];
  logic signed [WIDTH-1:0] snap_r [N_SRC];
  logic        [4:0]       snap_g [N_SRC];
  logic        [4:0]       snap_m;
  logic        [IDX_W-1:0] idx;
  logic signed [ACC_W-1:0] acc_l, acc_r;

  logic signed [SCL_W-1:0] op_l, op_r, op_g, prod_l, prod_r, m_l, m_r;
  logic signed [WIDTH-1:0] sat_l, sat_r;
  logic                    clip_l, clip_r;
  logic        [23:0]      just_l, just_r;
  logic                    last_src;

  function automatic logic [4:0] clamp_gain(input logic [4:0] g);
    return (g > 5'd16) ? 5'd16 : g;
  endfunction

  assign busy     = (state_q != IDLE);
  assign last_src = (idx == IDX_W'(N_SRC - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (next_sample) state_d = ACCUM;
      ACCUM:   if (last_src) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The same multiplier pair serves the per-source and master-gain products.
  always_comb begin
    op_l = SCL_W'(snap_l[idx]);
    op_r = SCL_W'(snap_r[idx]);
    op_g = SCL_W'(snap_g[idx]);
    if (state_q == SCALE) begin
      op_l = SCL_W'(acc_l);
      op_r = SCL_W'(acc_r);
      op_g = SCL_W'(snap_m);
    end
    prod_l = op_l * op_g;
    prod_r = op_r * op_g;
    m_l    = prod_l >>> 8;
    m_r    = prod_r >>> 8;
  end

  always_comb begin
    sat_l  = m_l[WIDTH-1:0];
    clip_l = 1'b0;
    if (m_l > SAT_MAX) begin
      sat_l  = SAT_MAX[WIDTH-1:0];
      clip_l = 1'b1;
    end else if (m_l < SAT_MIN) begin
      sat_l  = SAT_MIN[WIDTH-1:0];
      clip_l = 1'b1;
    end
    sat_r  = m_r[WIDTH-1:0];
    clip_r = 1'b0;
    if (m_r > SAT_MAX) begin
      sat_r  = SAT_MAX[WIDTH-1:0];
      clip_r = 1'b1;
    end else if (m_r < SAT_MIN) begin
      sat_r  = SAT_MIN[WIDTH-1:0];
      clip_r = 1'b1;
    end
  end

  // Sign-extension bits are shifted out, leaving {sat, zeros}.
  assign just_l = 24'($unsigned(sat_l)) << (24 - WIDTH);
  assign just_r = 24'($unsigned(sat_r)) << (24 - WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        snap_l[i] <= '0;
        snap_r[i] <= '0;
        snap_g[i] <= '0;
      end
      snap_m     <= '0;
      idx        <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      clip      <= (clip & ~flags_clear) | ((state_q == SCALE) & (clip_l | clip_r));
      overrun   <= (overrun & ~flags_clear) | (next_sample & busy);
      case (state_q)
        IDLE: begin
          if (next_sample) begin
            for (int i = 0; i < N_SRC; i++) begin
              snap_l[i] <= src_left[i*WIDTH +: WIDTH];
              snap_r[i] <= src_right[i*WIDTH +: WIDTH];
              snap_g[i] <= clamp_gain(src_gain[i*5 +: 5]);
            end
            snap_m <= clamp_gain(master_gain);
            idx    <= '0;
            acc_l  <= '0;
            acc_r  <= '0;
          end
        end
        ACCUM: begin
          acc_l <= acc_l + ACC_W'(prod_l);
          acc_r <= acc_r + ACC_W'(prod_r);
          idx   <= idx + IDX_W'(1);
        end
        SCALE: begin
          left_data  <= just_l;
          right_data <= just_r;
          out_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Randomized and directed bench for audio_mixer (N_SRC=2, WIDTH=16) against
// an arithmetic reference model of the mix.
module tb_audio_mixer;
  localparam int N = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, next_sample, flags_clear;
  logic [N*W-1:0]   src_left, src_right;
  logic [N*5-1:0]   src_gain;
  logic [4:0]       master_gain;
  logic [23:0]      left_data, right_data;
  logic             out_valid, busy, clip, overrun;

  logic signed [W-1:0] sl [N];
  logic signed [W-1:0] sr [N];
  logic        [4:0]   sg [N];

  int errors = 0;
  int checks = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_left[i*W +: W]  = sl[i];
      src_right[i*W +: W] = sr[i];
      src_gain[i*5 +: 5]  = sg[i];
    end
  end

  audio_mixer #(.N_SRC(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample),
    .src_left(src_left), .src_right(src_right), .src_gain(src_gain),
    .master_gain(master_gain), .flags_clear(flags_clear),
    .left_data(left_data), .right_data(right_data), .out_valid(out_valid),
    .busy(busy), .clip(clip), .overrun(overrun)
  );

  function automatic longint floor256(input longint x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  // Expected justified output of one channel from the current input values.
  function automatic logic [23:0] ref_chan(input bit right, output bit c);
    longint acc, m;
    int g;
    logic [23:0] r;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      g = (sg[i] > 16) ? 16 : int'(sg[i]);
      acc += (right ? longint'(sr[i]) : longint'(sl[i])) * g;
    end
    g = (master_gain > 16) ? 16 : int'(master_gain);
    m = floor256(acc * g);
    c = 1'b0;
    if (m > 32767) begin m = 32767; c = 1'b1; end
    else if (m < -32768) begin m = -32768; c = 1'b1; end
    r = 24'(m[W-1:0]);
    return r << (24 - W);
  endfunction

  task automatic run_mix(output int lat);
    lat = 0;
    next_sample = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) next_sample = 1'b0;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; next_sample = 1'b0; flags_clear = 1'b0; master_gain = '0;
    for (int i = 0; i < N; i++) begin sl[i] = '0; sr[i] = '0; sg[i] = '0; end
    repeat (3) @(negedge clk);
    checks++; if (left_data !== 24'h0) begin errors++; $display("FAIL reset_left got=%h exp=000000", left_data); end
    checks++; if (right_data !== 24'h0) begin errors++; $display("FAIL reset_right got=%h exp=000000", right_data); end
    checks++; if ({out_valid, busy, clip, overrun} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, clip, overrun}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gain_mix();
    logic [23:0] er; bit c;
    sl[0] = 16'sh4000; sg[0] = 5'd16; sl[1] = 16'sh2000; sg[1] = 5'd8;
    sr[0] = -16'sd300; sr[1] = 16'sd1234; master_gain = 5'd16;
    er = ref_chan(1'b1, c);
    next_sample = 1'b1;
    for (int c2 = 1; c2 <= N + 2; c2++) begin
      @(negedge clk);
      if (c2 == 1) next_sample = 1'b0;
      checks++; if (busy !== (c2 <= N + 1)) begin errors++;
        $display("FAIL gain_busy cycle=%0d got=%b exp=%b", c2, busy, (c2 <= N + 1)); end
      checks++; if (out_valid !== (c2 == N + 2)) begin errors++;
        $display("FAIL gain_valid cycle=%0d got=%b exp=%b", c2, out_valid, (c2 == N + 2)); end
    end
    checks++; if (left_data !== 24'h500000) begin errors++; $display("FAIL gain_left got=%h exp=500000", left_data); end
    checks++; if (right_data !== er) begin errors++; $display("FAIL gain_right got=%h exp=%h", right_data, er); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL gain_clip got=%b exp=0", clip); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || left_data !== 24'h500000) begin errors++;
      $display("FAIL gain_hold valid=%b left=%h exp valid=0 left=500000", out_valid, left_data); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin errors++;
      $display("FAIL midrst_data got=%h/%h exp=000000/000000", left_data, right_data); end
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++;
      $display("FAIL midrst_state valid/busy got=%b exp=00", {out_valid, busy}); end
    pulses = 0;
    repeat (N + 4) begin @(negedge clk); if (out_valid === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_novalid got=%0d exp=0", pulses); end
  endtask

  task automatic test_clip();
    int lat;
    for (int i = 0; i < N; i++) begin sl[i] = 16'sh7FFF; sr[i] = 16'sh7FFF; sg[i] = 5'd16; end
    master_gain = 5'd16;
    flags_clear = 1'b1;
    run_mix(lat);
    checks++; if (lat != N + 2) begin errors++; $display("FAIL clip_latency got=%0d exp=%0d", lat, N + 2); end
    checks++; if (left_data !== 24'h7FFF00 || right_data !== 24'h7FFF00) begin errors++;
      $display("FAIL clip_data got=%h/%h exp=7fff00/7fff00", left_data, right_data); end
    checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_setwins got=%b exp=1", clip); end
    flags_clear = 1'b0;
    @(negedge clk);
    checks++; if (clip !== 1'b1) begin errors++; $display("FAIL clip_sticky got=%b exp=1", clip); end
    pulse_clear();
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL clip_cleared got=%b exp=0", clip); end
    checks++; if (left_data !== 24'h7FFF00) begin errors++; $display("FAIL clip_hold got=%h exp=7fff00", left_data); end
  endtask

  task automatic test_neg_clip_mute();
    int lat;
    logic [4:0] gl [3];
    logic [23:0] ex [3];
    gl[0] = 5'd16; gl[1] = 5'd0; gl[2] = 5'd31;
    ex[0] = 24'h800000; ex[1] = 24'h000000; ex[2] = 24'h800000;
    master_gain = 5'd16;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin sl[i] = 16'sh8000; sr[i] = 16'sh8000; sg[i] = gl[k]; end
      run_mix(lat);
      checks++; if (left_data !== ex[k]) begin errors++;
        $display("FAIL negclip_left gain=%0d got=%h exp=%h", gl[k], left_data, ex[k]); end
      checks++; if (clip !== (gl[k] != 0)) begin errors++;
        $display("FAIL negclip_clip gain=%0d got=%b exp=%b", gl[k], clip, (gl[k] != 0)); end
      pulse_clear();
    end
  endtask

  task automatic test_overrun_snapshot();
    logic [23:0] el, er, gotl, gotr; bit c;
    int pulses, first;
    for (int ov = 2; ov <= N + 1; ov++) begin
      pulse_clear();
      sl[0] = 16'sh1234; sl[1] = -16'sh0800; sr[0] = -16'sh2222; sr[1] = 16'sh0100;
      sg[0] = 5'd12; sg[1] = 5'd20; master_gain = 5'd16;
      el = ref_chan(1'b0, c); er = ref_chan(1'b1, c);
      pulses = 0; first = 0; gotl = '0; gotr = '0;
      next_sample = 1'b1;
      for (int c2 = 1; c2 <= N + 6; c2++) begin
        @(negedge clk);
        next_sample = (c2 == ov);
        if (c2 == 1) begin
          for (int i = 0; i < N; i++) begin
            sl[i] = W'($urandom); sr[i] = W'($urandom); sg[i] = 5'($urandom);
          end
          master_gain = 5'($urandom);
        end
        if (out_valid === 1'b1) begin
          pulses++;
          if (first == 0) begin first = c2; gotl = left_data; gotr = right_data; end
        end
      end
      checks++; if (pulses != 1 || first != N + 2) begin errors++;
        $display("FAIL ovr_valid at=%0d pulses=%0d first=%0d exp 1 at %0d", ov, pulses, first, N + 2); end
      checks++; if (gotl !== el || gotr !== er) begin errors++;
        $display("FAIL ovr_snapshot at=%0d got=%h/%h exp=%h/%h", ov, gotl, gotr, el, er); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag at=%0d got=%b exp=1", ov, overrun); end
    end
    pulse_clear();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_master();
    int lat;
    logic [4:0] ml [2];
    logic [23:0] ex [2];
    ml[0] = 5'd4; ml[1] = 5'd0; ex[0] = 24'h040000; ex[1] = 24'h000000;
    for (int i = 0; i < N; i++) begin sl[i] = 16'sh5555; sr[i] = '0; sg[i] = 5'd0; end
    sl[0] = 16'sh1000; sg[0] = 5'd16;
    for (int k = 0; k < 2; k++) begin
      master_gain = ml[k];
      run_mix(lat);
      checks++; if (left_data !== ex[k]) begin errors++;
        $display("FAIL master_left mg=%0d got=%h exp=%h", ml[k], left_data, ex[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] el, er; bit c;
    pulse_clear();
    for (int i = 0; i < N; i++) begin sl[i] = W'($urandom); sr[i] = W'($urandom); sg[i] = 5'($urandom_range(0, 16)); end
    master_gain = 5'd16;
    el = ref_chan(1'b0, c); er = ref_chan(1'b1, c);
    next_sample = 1'b1;
    for (int c2 = 1; c2 <= 2 * N + 4; c2++) begin
      @(negedge clk);
      next_sample = 1'b0;
      if (c2 == N + 2 || c2 == 2 * N + 4) begin
        checks++; if (out_valid !== 1'b1 || left_data !== el || right_data !== er) begin errors++;
          $display("FAIL b2b_result cycle=%0d valid=%b got=%h/%h exp=%h/%h", c2, out_valid, left_data, right_data, el, er); end
      end
      if (c2 == N + 2) begin
        for (int i = 0; i < N; i++) begin sl[i] = W'($urandom); sr[i] = W'($urandom); sg[i] = 5'($urandom); end
        master_gain = 5'($urandom);
        el = ref_chan(1'b0, c); er = ref_chan(1'b1, c);
        next_sample = 1'b1;
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_random();
    logic [23:0] el, er; bit cl, cr;
    int lat;
    for (int t = 0; t < 40; t++) begin
      pulse_clear();
      for (int i = 0; i < N; i++) begin
        sl[i] = W'($urandom); sr[i] = W'($urandom); sg[i] = 5'($urandom_range(0, 31));
      end
      if (t % 4 == 0) begin sl[0] = 16'sh7FF0; sl[1] = 16'sh7000; sg[0] = 5'd16; sg[1] = 5'd16; end
      master_gain = 5'($urandom_range(0, 31));
      el = ref_chan(1'b0, cl); er = ref_chan(1'b1, cr);
      run_mix(lat);
      checks++; if (lat != N + 2) begin errors++; $display("FAIL rand_latency t=%0d got=%0d exp=%0d", t, lat, N + 2); end
      checks++; if (left_data !== el || right_data !== er) begin errors++;
        $display("FAIL rand_data t=%0d got=%h/%h exp=%h/%h", t, left_data, right_data, el, er); end
      checks++; if (clip !== (cl | cr)) begin errors++; $display("FAIL rand_clip t=%0d got=%b exp=%b", t, clip, cl | cr); end
    end
  endtask

  initial begin
    test_reset();
    test_gain_mix();
    test_reset_mid();
    test_clip();
    test_neg_clip_mute();
    test_overrun_snapshot();
    test_master();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
